// File: rtl/star_cam_sub_resp.sv
// CAM/SUB responder: 64-entry key LUT answering match (CAMSUB) and key-difference (FindSub) requests.
// Latency: CAMSUB 1 cycle, FindSub 2 cycles fully pipelined, req_err 1 cycle.
// Backpressure: none; requests outside READY, or colliding FindSub, are dropped with a req_err pulse.
module star_cam_sub_resp #(
    parameter int LUT_LEN = 64,
    parameter int KEY_W   = 8,
    parameter int IDX_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               lut_we,
    input  logic [IDX_W-1:0]   lut_waddr,
    input  logic [KEY_W-1:0]   lut_wdata,
    output logic               lut_ready,
    input  logic               CAMSUB_req,
    input  logic [KEY_W-1:0]   xi,
    output logic [LUT_LEN-1:0] xi_MV,
    output logic               xi_valid,
    input  logic               FindSub_req,
    input  logic [LUT_LEN-1:0] xmax_MV,
    input  logic [LUT_LEN-1:0] xi_MV_in,
    output logic [LUT_LEN-1:0] sub_MV,
    output logic               sub_valid,
    output logic               miss,
    output logic               req_err
);

    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

    typedef struct packed {
        logic             vld;
        logic             zero;
        logic [IDX_W-1:0] imax;
        logic [IDX_W-1:0] ixi;
    } s1_t;

    state_t state, state_nxt;
    s1_t    s1;

    logic [KEY_W-1:0] lut [LUT_LEN];

    logic               req_ok, cam_acc, fs_acc, rej;
    logic [LUT_LEN-1:0] cam_hit, sub_hit;
    logic [KEY_W-1:0]   key_max, key_xi, diff;
    logic               sub_fire;

    function automatic logic [IDX_W-1:0] hi_idx(input logic [LUT_LEN-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int k = 0; k < LUT_LEN; k++) begin
            if (v[k]) idx = IDX_W'(k);
        end
        return idx;
    endfunction

    // State machine
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (lut_we) state_nxt = LOAD;
            LOAD:  if (lut_we && lut_waddr == IDX_W'(LUT_LEN - 1)) state_nxt = READY;
            READY: if (lut_we) state_nxt = LOAD;
            default: state_nxt = EMPTY;
        endcase
    end

    assign lut_ready = (state == READY);

    // Key storage is deliberately not reset; contents are only meaningful after a full load.
    always_ff @(posedge clk) begin
        if (lut_we) lut[lut_waddr] <= lut_wdata;
    end

    // A write in the request cycle always wins: it either invalidates READY or we weren't READY.
    assign req_ok  = (state == READY) && !lut_we;
    assign cam_acc = CAMSUB_req && req_ok;
    assign fs_acc  = FindSub_req && !CAMSUB_req && req_ok;
    assign rej     = (CAMSUB_req && !req_ok) || (FindSub_req && !fs_acc);

    always_comb begin
        cam_hit = '0;
        for (int k = 0; k < LUT_LEN; k++) cam_hit[k] = (lut[k] == xi);
    end

    // FindSub stage 1: reduce match vectors to indices.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
        end else begin
            s1.vld  <= fs_acc;
            s1.zero <= ~|xmax_MV || ~|xi_MV_in;
            s1.imax <= hi_idx(xmax_MV);
            s1.ixi  <= hi_idx(xi_MV_in);
        end
    end

    // FindSub stage 2: saturating difference and its match; any write flushes the in-flight op.
    assign key_max  = lut[s1.imax];
    assign key_xi   = lut[s1.ixi];
    assign diff     = (key_max < key_xi) ? '0 : key_max - key_xi;
    assign sub_fire = s1.vld && !lut_we;

    always_comb begin
        sub_hit = '0;
        if (!s1.zero) begin
            for (int k = 0; k < LUT_LEN; k++) sub_hit[k] = (lut[k] == diff);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xi_MV     <= '0;
            xi_valid  <= 1'b0;
            sub_MV    <= '0;
            sub_valid <= 1'b0;
            miss      <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            xi_valid  <= cam_acc;
            sub_valid <= sub_fire;
            req_err   <= rej;
            miss      <= (cam_acc && ~|cam_hit) || (sub_fire && ~|sub_hit);
            if (cam_acc)  xi_MV  <= cam_hit;
            if (sub_fire) sub_MV <= sub_hit;
        end
    end

endmodule

// File: tb/tb_star_cam_sub_resp.sv
// Directed self-checking bench for star_cam_sub_resp.
module tb_star_cam_sub_resp;
    localparam int LUT_LEN = 64;
    localparam int KEY_W   = 8;
    localparam int IDX_W   = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic               lut_we;
    logic [IDX_W-1:0]   lut_waddr;
    logic [KEY_W-1:0]   lut_wdata;
    logic               lut_ready;
    logic               CAMSUB_req;
    logic [KEY_W-1:0]   xi;
    logic [LUT_LEN-1:0] xi_MV;
    logic               xi_valid;
    logic               FindSub_req;
    logic [LUT_LEN-1:0] xmax_MV;
    logic [LUT_LEN-1:0] xi_MV_in;
    logic [LUT_LEN-1:0] sub_MV;
    logic               sub_valid;
    logic               miss;
    logic               req_err;

    int errs = 0;
    int nchk = 0;

    star_cam_sub_resp #(.LUT_LEN(LUT_LEN), .KEY_W(KEY_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .lut_ready(lut_ready),
        .CAMSUB_req(CAMSUB_req), .xi(xi), .xi_MV(xi_MV), .xi_valid(xi_valid),
        .FindSub_req(FindSub_req), .xmax_MV(xmax_MV), .xi_MV_in(xi_MV_in),
        .sub_MV(sub_MV), .sub_valid(sub_valid), .miss(miss), .req_err(req_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lut_we = 0; lut_waddr = '0; lut_wdata = '0;
        CAMSUB_req = 0; xi = '0;
        FindSub_req = 0; xmax_MV = '0; xi_MV_in = '0;
    endtask

    task automatic load_ident(input int from);
        for (int k = from; k < LUT_LEN; k++) begin
            lut_we = 1; lut_waddr = IDX_W'(k); lut_wdata = KEY_W'(k);
            cyc();
        end
        lut_we = 0;
    endtask

    task automatic test_reset();
        reset = 0; idle();
        cyc(); cyc();
        nchk++; if (xi_MV !== '0)  begin errs++; $display("FAIL reset_xi_MV got %h want 0", xi_MV); end
        nchk++; if (sub_MV !== '0) begin errs++; $display("FAIL reset_sub_MV got %h want 0", sub_MV); end
        nchk++; if ({lut_ready, xi_valid, sub_valid, miss, req_err} !== 5'b0)
            begin errs++; $display("FAIL reset_flags got %b want 00000", {lut_ready, xi_valid, sub_valid, miss, req_err}); end
        reset = 1;
        cyc();
    endtask

    task automatic test_reject_empty();
        CAMSUB_req = 1; xi = 8'd17;
        cyc();
        CAMSUB_req = 0;
        nchk++; if (req_err !== 1'b1)  begin errs++; $display("FAIL empty_req_err got %b want 1", req_err); end
        nchk++; if (xi_valid !== 1'b0) begin errs++; $display("FAIL empty_xi_valid got %b want 0", xi_valid); end
        cyc();
        nchk++; if (req_err !== 1'b0)  begin errs++; $display("FAIL empty_req_err_pulse got %b want 0", req_err); end
    endtask

    task automatic test_load();
        for (int k = 0; k < LUT_LEN; k++) begin
            lut_we = 1; lut_waddr = IDX_W'(k); lut_wdata = KEY_W'(k);
            cyc();
            if (k == LUT_LEN - 2) begin
                nchk++; if (lut_ready !== 1'b0) begin errs++; $display("FAIL load_ready_early got %b want 0", lut_ready); end
            end
        end
        lut_we = 0;
        nchk++; if (lut_ready !== 1'b1) begin errs++; $display("FAIL load_ready got %b want 1", lut_ready); end
    endtask

    task automatic test_camsub();
        logic [LUT_LEN-1:0] exp;
        exp = '0; exp[17] = 1'b1;
        CAMSUB_req = 1; xi = 8'd17;
        cyc();
        CAMSUB_req = 0;
        nchk++; if (xi_valid !== 1'b1) begin errs++; $display("FAIL cam_valid got %b want 1", xi_valid); end
        nchk++; if (xi_MV !== exp)     begin errs++; $display("FAIL cam_mv got %h want %h", xi_MV, exp); end
        nchk++; if (miss !== 1'b0)     begin errs++; $display("FAIL cam_miss got %b want 0", miss); end
        cyc();
        nchk++; if (xi_valid !== 1'b0) begin errs++; $display("FAIL cam_valid_pulse got %b want 0", xi_valid); end
        nchk++; if (xi_MV !== exp)     begin errs++; $display("FAIL cam_mv_hold got %h want %h", xi_MV, exp); end
    endtask

    task automatic test_dup_miss();
        logic [LUT_LEN-1:0] exp;
        exp = '0; exp[3] = 1'b1; exp[40] = 1'b1;
        lut_we = 1; lut_waddr = 6'd3;  lut_wdata = 8'hA5; cyc();
        lut_waddr = 6'd40; cyc();
        lut_waddr = 6'd63; lut_wdata = 8'd63; cyc();
        lut_we = 0;
        CAMSUB_req = 1; xi = 8'hA5;
        cyc();
        nchk++; if (xi_MV !== exp || xi_valid !== 1'b1)
            begin errs++; $display("FAIL dup_mv got %h/%b want %h/1", xi_MV, xi_valid, exp); end
        xi = 8'hFF;
        cyc();
        CAMSUB_req = 0;
        nchk++; if (xi_MV !== '0) begin errs++; $display("FAIL miss_mv got %h want 0", xi_MV); end
        nchk++; if (miss !== 1'b1 || xi_valid !== 1'b1)
            begin errs++; $display("FAIL miss_flag got %b/%b want 1/1", miss, xi_valid); end
        lut_we = 1; lut_waddr = 6'd3;  lut_wdata = 8'd3;  cyc();
        lut_waddr = 6'd40; lut_wdata = 8'd40; cyc();
        lut_waddr = 6'd63; lut_wdata = 8'd63; cyc();
        lut_we = 0;
    endtask

    task automatic test_back_to_back();
        logic [LUT_LEN-1:0] exp;
        logic               ev;
        exp = '0; exp[30] = 1'b1;
        xmax_MV = '0; xmax_MV[50] = 1'b1;
        xi_MV_in = '0; xi_MV_in[20] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            FindSub_req = (i < 3);
            cyc();
            ev = (i >= 1 && i <= 3);
            nchk++; if (sub_valid !== ev) begin errs++; $display("FAIL b2b_valid[%0d] got %b want %b", i, sub_valid, ev); end
            if (ev) begin
                nchk++; if (sub_MV !== exp || miss !== 1'b0)
                    begin errs++; $display("FAIL b2b_mv[%0d] got %h/%b want %h/0", i, sub_MV, miss, exp); end
            end
        end
        FindSub_req = 0;
    endtask

    task automatic test_saturation();
        logic [LUT_LEN-1:0] exp;
        exp = '0; exp[0] = 1'b1;
        xmax_MV = '0; xmax_MV[5] = 1'b1;
        xi_MV_in = '0; xi_MV_in[9] = 1'b1;
        FindSub_req = 1; cyc(); FindSub_req = 0; cyc();
        nchk++; if (sub_valid !== 1'b1 || sub_MV !== exp || miss !== 1'b0)
            begin errs++; $display("FAIL sat got %b/%h/%b want 1/%h/0", sub_valid, sub_MV, miss, exp); end
        xmax_MV = '0;
        FindSub_req = 1; cyc(); FindSub_req = 0; cyc();
        nchk++; if (sub_valid !== 1'b1 || sub_MV !== '0 || miss !== 1'b1)
            begin errs++; $display("FAIL zero_in got %b/%h/%b want 1/0/1", sub_valid, sub_MV, miss); end
    endtask

    task automatic test_collision();
        CAMSUB_req = 1; FindSub_req = 1; xi = 8'd17;
        xmax_MV = '0; xmax_MV[50] = 1'b1;
        xi_MV_in = '0; xi_MV_in[20] = 1'b1;
        cyc();
        CAMSUB_req = 0; FindSub_req = 0;
        nchk++; if (xi_valid !== 1'b1 || req_err !== 1'b1)
            begin errs++; $display("FAIL coll_first got valid=%b err=%b want 1/1", xi_valid, req_err); end
        cyc();
        nchk++; if (sub_valid !== 1'b0 || req_err !== 1'b0)
            begin errs++; $display("FAIL coll_second got sub=%b err=%b want 0/0", sub_valid, req_err); end
    endtask

    task automatic test_flush_reload();
        xmax_MV = '0; xmax_MV[50] = 1'b1;
        xi_MV_in = '0; xi_MV_in[20] = 1'b1;
        FindSub_req = 1; cyc(); FindSub_req = 0;
        lut_we = 1; lut_waddr = 6'd0; lut_wdata = 8'd0;
        cyc();
        nchk++; if (sub_valid !== 1'b0) begin errs++; $display("FAIL flush_sub_valid got %b want 0", sub_valid); end
        nchk++; if (lut_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got %b want 0", lut_ready); end
        load_ident(1);
        nchk++; if (lut_ready !== 1'b1) begin errs++; $display("FAIL reload_ready got %b want 1", lut_ready); end
        // write and request in the same cycle
        lut_we = 1; lut_waddr = 6'd63; lut_wdata = 8'd63; CAMSUB_req = 1; xi = 8'd17;
        cyc();
        lut_we = 0; CAMSUB_req = 0;
        nchk++; if (req_err !== 1'b1 || xi_valid !== 1'b0 || lut_ready !== 1'b0)
            begin errs++; $display("FAIL wr_req got err=%b valid=%b rdy=%b want 1/0/0", req_err, xi_valid, lut_ready); end
        load_ident(0);
    endtask

    task automatic test_reset_mid();
        CAMSUB_req = 1; xi = 8'd17;
        cyc();
        CAMSUB_req = 0;
        nchk++; if (xi_valid !== 1'b1) begin errs++; $display("FAIL pre_reset_valid got %b want 1", xi_valid); end
        reset = 0;
        #1;
        nchk++; if (xi_MV !== '0 || xi_valid !== 1'b0 || lut_ready !== 1'b0)
            begin errs++; $display("FAIL async_reset got mv=%h v=%b rdy=%b want 0/0/0", xi_MV, xi_valid, lut_ready); end
        cyc();
        reset = 1;
        CAMSUB_req = 1;
        cyc();
        CAMSUB_req = 0;
        nchk++; if (req_err !== 1'b1 || xi_valid !== 1'b0)
            begin errs++; $display("FAIL post_reset_req got err=%b v=%b want 1/0", req_err, xi_valid); end
    endtask

    initial begin
        test_reset();
        test_reject_empty();
        test_load();
        test_camsub();
        test_dup_miss();
        test_back_to_back();
        test_saturation();
        test_collision();
        test_flush_reload();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
